// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the generic pipeline stage register.
// Contents:
//   NOP_INSTR     - canonical bubble instruction (addi x0, x0, 0)
//   skid_state_e  - occupancy state of a stage (doubles as the entry count)
//   *_t structs   - inter-stage payloads; $bits() of each sets DATA_W
//   *_BUBBLE      - per-stage bubbles: instr = NOP, every write-enable low
package pipe_skid_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Encoded so that the state value is also the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_we;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] alu_res;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_we;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_we;
    } mem_wb_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, instr: NOP_INSTR};

    localparam id_ex_t ID_EX_BUBBLE = '{pc: 32'h0, instr: NOP_INSTR,
                                        rs1_val: 32'h0, rs2_val: 32'h0,
                                        imm: 32'h0, rd: 5'd0,
                                        reg_we: 1'b0, mem_we: 1'b0};

    localparam ex_mem_t EX_MEM_BUBBLE = '{instr: NOP_INSTR, alu_res: 32'h0,
                                          store_data: 32'h0, rd: 5'd0,
                                          reg_we: 1'b0, mem_we: 1'b0};

    localparam mem_wb_t MEM_WB_BUBBLE = '{instr: NOP_INSTR, wb_data: 32'h0,
                                          rd: 5'd0, reg_we: 1'b0};

    // Number of held entries represented by a state.
    function automatic logic [1:0] count_of(input skid_state_e st);
        return 2'(st);
    endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle between an upstream producer, the stage, and a
// downstream consumer.
//   i_in_valid / o_in_ready / i_in_data    : upstream side
//   o_out_valid / i_out_ready / o_out_data : downstream side
//   o_count                                : entries currently held
// modport slave is the stage itself; modport master is whatever drives it.
interface pipe_skid_stage_if #(
    parameter int DATA_W = 32
) ();

    logic              i_in_valid;
    logic              o_in_ready;
    logic [DATA_W-1:0] i_in_data;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [DATA_W-1:0] o_out_data;
    logic [1:0]        o_count;

    modport master (
        output i_in_valid, i_in_data, i_out_ready,
        input  o_in_ready, o_out_valid, o_out_data, o_count
    );

    modport slave (
        input  i_in_valid, i_in_data, i_out_ready,
        output o_in_ready, o_out_valid, o_out_data, o_count
    );

endinterface

// File: rtl/pipe_skid_stage.sv
// Generic pipeline stage register with valid/ready handshake.
// Ports:
//   i_clk   - clock, rising edge
//   i_reset - synchronous reset, active high (highest priority)
//   i_flush - synchronous kill of every held entry
//   bus     - pipe_skid_stage_if.slave handshake bundle
// SKID_EN=1: two entries (head + skid), o_in_ready comes straight from a
//            flop, so i_out_ready never reaches o_in_ready combinationally.
// SKID_EN=0: single head register, o_in_ready = !o_out_valid | i_out_ready.
// While empty the head register holds BUBBLE_VAL, so downstream always
// decodes a NOP.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(NOP_INSTR),
    parameter bit                SKID_EN    = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    pipe_skid_stage_if.slave  bus
);

    skid_state_e       state_r, state_s;
    logic [DATA_W-1:0] head_r, head_s;
    logic [DATA_W-1:0] skid_r, skid_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              in_ready_s;
    logic              in_fire_s;
    logic              out_fire_s;

    // Upstream ready: flop in skid mode, pass-through of downstream otherwise.
    always_comb begin
        in_ready_s = 1'b0;
        if (SKID_EN == 1'b1) begin
            in_ready_s = in_ready_r;
        end else begin
            in_ready_s = ~out_valid_r | bus.i_out_ready;
        end
    end

    assign in_fire_s  = bus.i_in_valid & in_ready_s;
    assign out_fire_s = out_valid_r & bus.i_out_ready;

    // Next occupancy state and entry contents.
    always_comb begin
        state_s = state_r;
        head_s  = head_r;
        skid_s  = skid_r;
        if (i_flush) begin
            // Same-cycle in_fire is dropped; a same-cycle out_fire was
            // already taken by downstream, so nothing else to do.
            state_s = ST_EMPTY;
            head_s  = BUBBLE_VAL;
            skid_s  = BUBBLE_VAL;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_s = ST_ONE;
                        head_s  = bus.i_in_data;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        head_s = bus.i_in_data;
                    end else if (in_fire_s && (SKID_EN == 1'b1)) begin
                        state_s = ST_TWO;
                        skid_s  = bus.i_in_data;
                    end else if (out_fire_s) begin
                        state_s = ST_EMPTY;
                        head_s  = BUBBLE_VAL;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the head can move.
                    if (out_fire_s) begin
                        state_s = ST_ONE;
                        head_s  = skid_r;
                        skid_s  = BUBBLE_VAL;
                    end else begin
                        state_s = ST_TWO;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                    head_s  = BUBBLE_VAL;
                    skid_s  = BUBBLE_VAL;
                end
            endcase
        end
    end

    // State, entry and flag registers; reset overrides everything.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r     <= ST_EMPTY;
            head_r      <= BUBBLE_VAL;
            skid_r      <= BUBBLE_VAL;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            head_r      <= head_s;
            skid_r      <= skid_s;
            in_ready_r  <= (state_s != ST_TWO);
            out_valid_r <= (state_s != ST_EMPTY);
        end
    end

    assign bus.o_in_ready  = in_ready_s;
    assign bus.o_out_valid = out_valid_r;
    assign bus.o_out_data  = head_r;
    assign bus.o_count     = count_of(state_r);

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage:
//   dut_a - 32-bit, skid buffer on   (table-driven vectors)
//   dut_b - 32-bit, skid buffer off  (hand-written sequence)
//   dut_c - 97-bit, skid buffer on   (random traffic against a queue model)
module tb_pipe_skid_stage;

    logic clk = 1'b0;
    logic rst;
    logic flush_a, flush_b, flush_c;
    int   n_assert = 0;
    int   n_fail   = 0;

    localparam logic [31:0] BUB32 = 32'h0000_0013;
    localparam logic [96:0] BUB97 = 97'h13;

    always #5 clk = ~clk;

    pipe_skid_stage_if #(.DATA_W(32)) bus_a ();
    pipe_skid_stage_if #(.DATA_W(32)) bus_b ();
    pipe_skid_stage_if #(.DATA_W(97)) bus_c ();

    pipe_skid_stage #(.DATA_W(32), .SKID_EN(1'b1)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_flush(flush_a), .bus(bus_a));
    pipe_skid_stage #(.DATA_W(32), .SKID_EN(1'b0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_flush(flush_b), .bus(bus_b));
    pipe_skid_stage #(.DATA_W(97), .SKID_EN(1'b1)) dut_c (
        .i_clk(clk), .i_reset(rst), .i_flush(flush_c), .bus(bus_c));

    typedef struct {
        logic        flush;
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        e_valid;
        logic [31:0] e_data;
        logic [1:0]  e_cnt;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic fl, input logic iv, input logic [31:0] d, input logic ordy,
                       input logic ev, input logic [31:0] ed, input logic [1:0] ec, input logic er);
        vec_t v;
        v.flush = fl; v.iv = iv; v.din = d; v.ordy = ordy;
        v.e_valid = ev; v.e_data = ed; v.e_cnt = ec; v.e_rdy = er;
        vecs.push_back(v);
    endtask

    task automatic chk_a(input string tag, input logic ev, input logic [31:0] ed,
                         input logic [1:0] ec, input logic er);
        chk({tag, "_valid"}, bus_a.o_out_valid, ev);
        chk({tag, "_data"},  bus_a.o_out_data,  ed);
        chk({tag, "_count"}, bus_a.o_count,     ec);
        chk({tag, "_ready"}, bus_a.o_in_ready,  er);
    endtask

    task automatic chk_b(input string tag, input logic ev, input logic [31:0] ed, input logic [1:0] ec);
        chk({tag, "_valid"}, bus_b.o_out_valid, ev);
        chk({tag, "_data"},  bus_b.o_out_data,  ed);
        chk({tag, "_count"}, bus_b.o_count,     ec);
    endtask

    initial begin
        logic [96:0]  q[$];
        logic [127:0] rnd;
        logic         r_iv, r_or, r_fl, m_in, m_out;
        logic [96:0]  r_d;

        // ---------------- reset with junk offered upstream ----------------
        rst = 1'b1;
        flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
        bus_a.i_in_valid = 1'b1; bus_a.i_in_data = 32'hDEAD_BEEF; bus_a.i_out_ready = 1'b0;
        bus_b.i_in_valid = 1'b1; bus_b.i_in_data = 32'hDEAD_BEEF; bus_b.i_out_ready = 1'b0;
        bus_c.i_in_valid = 1'b1; bus_c.i_in_data = 97'hDEAD_BEEF;  bus_c.i_out_ready = 1'b0;
        step();
        step();
        chk_a("a_reset", 1'b0, BUB32, 2'd0, 1'b1);
        chk_b("b_reset", 1'b0, BUB32, 2'd0);
        chk("c_reset_valid", bus_c.o_out_valid, 1'b0);
        chk("c_reset_data",  bus_c.o_out_data,  BUB97);
        rst = 1'b0;
        bus_a.i_in_valid = 1'b0; bus_b.i_in_valid = 1'b0; bus_c.i_in_valid = 1'b0;
        step();
        chk_a("a_post_reset", 1'b0, BUB32, 2'd0, 1'b1);

        // ---------------- table-driven vectors on dut_a ----------------
        // fl iv din ordy | valid data cnt rdy (after the edge)
        for (int k = 1; k <= 8; k++) add(1'b0, 1'b1, 32'(k), 1'b1, 1'b1, 32'(k), 2'd1, 1'b1);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, BUB32,  2'd0, 1'b1);
        // backpressure: A then B fill both entries, further offers ignored
        add(1'b0, 1'b1, 32'hA,  1'b0, 1'b1, 32'hA,  2'd1, 1'b1);
        add(1'b0, 1'b1, 32'hB,  1'b0, 1'b1, 32'hA,  2'd2, 1'b0);
        add(1'b0, 1'b1, 32'h99, 1'b0, 1'b1, 32'hA,  2'd2, 1'b0);
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'hA,  2'd2, 1'b0);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hB,  2'd1, 1'b1);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, BUB32,  2'd0, 1'b1);
        // flush with two entries held and C offered
        add(1'b0, 1'b1, 32'h1A, 1'b0, 1'b1, 32'h1A, 2'd1, 1'b1);
        add(1'b0, 1'b1, 32'h1B, 1'b0, 1'b1, 32'h1A, 2'd2, 1'b0);
        add(1'b1, 1'b1, 32'hC,  1'b0, 1'b0, BUB32,  2'd0, 1'b1);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, BUB32,  2'd0, 1'b1);
        // flush with a real in_fire and out_fire in the same cycle
        add(1'b0, 1'b1, 32'hD,  1'b0, 1'b1, 32'hD,  2'd1, 1'b1);
        add(1'b1, 1'b1, 32'hC,  1'b1, 1'b0, BUB32,  2'd0, 1'b1);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, BUB32,  2'd0, 1'b1);
        // simultaneous in & out with one entry replaces the head
        add(1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 32'h55, 2'd1, 1'b1);
        add(1'b0, 1'b1, 32'h66, 1'b1, 1'b1, 32'h66, 2'd1, 1'b1);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, BUB32,  2'd0, 1'b1);

        foreach (vecs[i]) begin
            flush_a = vecs[i].flush;
            bus_a.i_in_valid  = vecs[i].iv;
            bus_a.i_in_data   = vecs[i].din;
            bus_a.i_out_ready = vecs[i].ordy;
            step();
            chk_a($sformatf("a_row%0d", i), vecs[i].e_valid, vecs[i].e_data, vecs[i].e_cnt, vecs[i].e_rdy);
        end
        flush_a = 1'b0; bus_a.i_in_valid = 1'b0;

        // ---------------- dut_b: no skid buffer ----------------
        chk("b_empty_ready", bus_b.o_in_ready, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            bus_b.i_in_valid = 1'b1; bus_b.i_in_data = 32'h20 + 32'(k); bus_b.i_out_ready = 1'b1;
            #1;
            chk($sformatf("b_stream%0d_ready", k), bus_b.o_in_ready, 1'b1);
            step();
            chk_b($sformatf("b_stream%0d", k), 1'b1, 32'h20 + 32'(k), 2'd1);
        end
        bus_b.i_in_data = 32'h30; bus_b.i_out_ready = 1'b0;
        #1;
        chk("b_stall_ready", bus_b.o_in_ready, 1'b0);
        step();
        chk_b("b_stall", 1'b1, 32'h28, 2'd1);
        bus_b.i_out_ready = 1'b1;
        #1;
        chk("b_bypass_ready", bus_b.o_in_ready, 1'b1);
        step();
        chk_b("b_replace", 1'b1, 32'h30, 2'd1);
        bus_b.i_in_valid = 1'b0;
        step();
        chk_b("b_drain", 1'b0, BUB32, 2'd0);
        bus_b.i_in_valid = 1'b1; bus_b.i_in_data = 32'h40; bus_b.i_out_ready = 1'b0;
        step();
        chk_b("b_load", 1'b1, 32'h40, 2'd1);
        flush_b = 1'b1; bus_b.i_in_data = 32'h41; bus_b.i_out_ready = 1'b1;
        step();
        chk_b("b_flush", 1'b0, BUB32, 2'd0);
        flush_b = 1'b0; bus_b.i_in_valid = 1'b0;
        step();
        chk_b("b_flush_after", 1'b0, BUB32, 2'd0);

        // ---------------- dut_c: random traffic vs. scoreboard ----------------
        for (int cyc = 0; cyc < 10000; cyc++) begin
            chk("c_valid", bus_c.o_out_valid, q.size() > 0);
            chk("c_data",  bus_c.o_out_data,  (q.size() > 0) ? q[0] : BUB97);
            chk("c_count", bus_c.o_count,     128'(q.size()));
            chk("c_ready", bus_c.o_in_ready,  q.size() < 2);
            rnd  = {$urandom, $urandom, $urandom, $urandom};
            r_d  = rnd[96:0];
            r_iv = ($urandom_range(0, 3) != 0);
            r_or = ($urandom_range(0, 1) != 0);
            r_fl = ($urandom_range(0, 63) == 0);
            bus_c.i_in_valid  = r_iv;
            bus_c.i_in_data   = r_d;
            bus_c.i_out_ready = r_or;
            flush_c           = r_fl;
            m_in  = r_iv && (q.size() < 2);
            m_out = r_or && (q.size() > 0);
            if (r_fl) begin
                q.delete();
            end else begin
                if (m_out) void'(q.pop_front());
                if (m_in) q.push_back(r_d);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
